// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/MAC result handshakes, decode scoreboard signals
// and the register-file write port, grouped for the write-back arbiter.
interface regfile_wb_arbiter_if;
    logic        alu_wr_valid;
    logic        alu_wr_ready;
    logic [3:0]  alu_wr_reg;
    logic [31:0] alu_wr_data;

    logic        mac_wr_valid;
    logic        mac_wr_ready;
    logic [3:0]  mac_wr_reg;
    logic [31:0] mac_wr_data;

    logic        mac_issue;
    logic [3:0]  mac_issue_reg;
    logic        mac_issue_ready;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic        hazard;

    logic        regwrite;
    logic [3:0]  write_reg;
    logic [31:0] write_data;

    modport slave (
        input  alu_wr_valid, alu_wr_reg, alu_wr_data,
        input  mac_wr_valid, mac_wr_reg, mac_wr_data,
        input  mac_issue, mac_issue_reg, rd_reg1, rd_reg2,
        output alu_wr_ready, mac_wr_ready, mac_issue_ready, hazard,
        output regwrite, write_reg, write_data
    );

    modport master (
        output alu_wr_valid, alu_wr_reg, alu_wr_data,
        output mac_wr_valid, mac_wr_reg, mac_wr_data,
        output mac_issue, mac_issue_reg, rd_reg1, rd_reg2,
        input  alu_wr_ready, mac_wr_ready, mac_issue_ready, hazard,
        input  regwrite, write_reg, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and buffered MAC results onto the single
// register-file write port. Define SCOREBOARD_EN to track pending MAC destinations.
module regfile_wb_arbiter #(
    parameter int unsigned MAC_DEPTH = 2,
    parameter int unsigned MAX_WAIT  = 4
) (
    input logic                 clock,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(MAC_DEPTH);
    localparam int unsigned CNT_W = $clog2(MAC_DEPTH + 1);
    localparam int unsigned STV_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAC_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_WAIT);

    logic [3:0]       fifo_reg_q  [MAC_DEPTH];
    logic [3:0]       fifo_reg_d  [MAC_DEPTH];
    logic [31:0]      fifo_data_q [MAC_DEPTH];
    logic [31:0]      fifo_data_d [MAC_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             regwrite_q, regwrite_d;
    logic [3:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;

    logic        full, empty, push, force_mac;
    logic        alu_grant, mac_grant;
    logic        waw_block, issue_ready, hazard;
    logic [3:0]  head_reg;
    logic [31:0] head_data;

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        // No push-through: a full FIFO refuses even when the head pops this cycle.
        push      = bus.mac_wr_valid && !full;
        head_reg  = fifo_reg_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
        force_mac = !empty && (starve_q == STV_MAX);
        alu_grant = bus.alu_wr_valid && !force_mac && !waw_block;
        mac_grant = !empty && !alu_grant;
    end

    always_comb begin
        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_reg_d[wr_ptr_q]  = bus.mac_wr_reg;
            fifo_data_d[wr_ptr_q] = bus.mac_wr_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (mac_grant) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(mac_grant);

        starve_d = starve_q;
        if (empty || mac_grant) begin
            starve_d = '0;
        end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + STV_W'(1);
        end

        regwrite_d   = alu_grant || mac_grant;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (alu_grant) begin
            write_reg_d  = bus.alu_wr_reg;
            write_data_d = bus.alu_wr_data;
        end else if (mac_grant) begin
            write_reg_d  = head_reg;
            write_data_d = head_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_reg_q   <= '{default: '0};
            fifo_data_q  <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            fifo_reg_q   <= fifo_reg_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef SCOREBOARD_EN
    logic [15:0] busy_q, busy_d;

    // Clear before set so a same-register issue in the grant cycle stays busy.
    always_comb begin
        busy_d = busy_q;
        if (mac_grant) begin
            busy_d[head_reg] = 1'b0;
        end
        if (bus.mac_issue && issue_ready) begin
            busy_d[bus.mac_issue_reg] = 1'b1;
        end
    end

    always_comb begin
        issue_ready = !busy_q[bus.mac_issue_reg];
        hazard      = busy_q[bus.rd_reg1] || busy_q[bus.rd_reg2];
        waw_block   = busy_q[bus.alu_wr_reg];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_scoreboard_inputs;

    always_comb begin
        issue_ready = 1'b1;
        hazard      = 1'b0;
        waw_block   = 1'b0;
        unused_scoreboard_inputs = ^{bus.mac_issue, bus.mac_issue_reg,
                                     bus.rd_reg1, bus.rd_reg2};
    end
`endif

    assign bus.alu_wr_ready    = alu_grant;
    assign bus.mac_wr_ready    = !full;
    assign bus.mac_issue_ready = issue_ready;
    assign bus.hazard          = hazard;
    assign bus.regwrite        = regwrite_q;
    assign bus.write_reg       = write_reg_q;
    assign bus.write_data      = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table plus directed sequences; expected register
// writes are queued with their due cycle and matched as regwrite pulses appear.
module tb_regfile_wb_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.MAC_DEPTH(2), .MAX_WAIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  rg;
        logic [31:0] data;
        int          due;
    } wr_exp_t;

    typedef struct {
        logic        valid;
        logic [3:0]  rg;
        logic [31:0] data;
        logic        exp_rdy;
    } alu_vec_t;

    wr_exp_t  exp_q[$];
    alu_vec_t vecs[6];

    logic       nxt_reset     = 1'b1;
    logic       nxt_issue     = 1'b0;
    logic [3:0] nxt_issue_reg = 4'd0;
    logic [3:0] nxt_rd1       = 4'd0;
    int         t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_wr(input logic [3:0] rg, input logic [31:0] data, input int due);
        wr_exp_t e;
        e.rg   = rg;
        e.data = data;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    // One cycle: drive at the falling edge, check handshake readies 1ns later.
    task automatic step(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [3:0] mr, input logic [31:0] md,
                        input logic exp_ar, input logic exp_mr, input string tag);
        @(negedge clock);
        reset             = nxt_reset;
        bus.mac_issue     = nxt_issue;
        bus.mac_issue_reg = nxt_issue_reg;
        bus.rd_reg1       = nxt_rd1;
        bus.alu_wr_valid  = av;
        bus.alu_wr_reg    = ar;
        bus.alu_wr_data   = ad;
        bus.mac_wr_valid  = mv;
        bus.mac_wr_reg    = mr;
        bus.mac_wr_data   = md;
        #1;
        check({tag, "_alu_ready"}, bus.alu_wr_ready, exp_ar);
        check({tag, "_mac_ready"}, bus.mac_wr_ready, exp_mr);
        if (exp_ar) expect_wr(ar, ad, cyc + 1);
    endtask

    task automatic idle(input logic exp_mr, input string tag);
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, exp_mr, tag);
    endtask

    always @(negedge clock) begin : write_monitor
        int idx;
        idx = -1;
        if (bus.regwrite === 1'b1) begin
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i].due == cyc) idx = i;
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual R%0d=%h at cycle %0d, required no write",
                         bus.write_reg, bus.write_data, cyc);
            end else begin
                check("write_reg", bus.write_reg, exp_q[idx].rg);
                check("write_data", bus.write_data, exp_q[idx].data);
                exp_q.delete(idx);
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write: actual none, required R%0d=%h at cycle %0d",
                         exp_q[i].rg, exp_q[i].data, exp_q[i].due);
                exp_q.delete(i);
            end
        end
    end

    initial begin
        bus.alu_wr_valid  = 1'b0;
        bus.alu_wr_reg    = 4'd0;
        bus.alu_wr_data   = 32'd0;
        bus.mac_wr_valid  = 1'b0;
        bus.mac_wr_reg    = 4'd0;
        bus.mac_wr_data   = 32'd0;
        bus.mac_issue     = 1'b0;
        bus.mac_issue_reg = 4'd0;
        bus.rd_reg1       = 4'd0;
        bus.rd_reg2       = 4'd0;

        vecs[0] = '{1'b1, 4'd3,  32'h12345678, 1'b1};
        vecs[1] = '{1'b1, 4'd0,  32'h00000000, 1'b1};
        vecs[2] = '{1'b0, 4'd7,  32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 4'd10, 32'h5A5A5A5A, 1'b1};
        vecs[4] = '{1'b1, 4'd10, 32'hA5A5A5A5, 1'b1};
        vecs[5] = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b1};

        repeat (3) @(negedge clock);

        // Reset state
        nxt_reset = 1'b0;
        idle(1'b1, "reset");
        check("reset_regwrite", bus.regwrite, 1'b0);
        check("reset_write_reg", bus.write_reg, 4'd0);
        check("reset_write_data", bus.write_data, 32'd0);
        check("reset_issue_ready", bus.mac_issue_ready, 1'b1);
        check("reset_hazard", bus.hazard, 1'b0);

        // ALU-only vectors, one cycle each, back to back
        for (int i = 0; i < 6; i++)
            step(vecs[i].valid, vecs[i].rg, vecs[i].data, 1'b0, 4'd0, 32'd0,
                 vecs[i].exp_rdy, 1'b1, "alu_vec");
        idle(1'b1, "alu_drain");
        idle(1'b1, "alu_hold");
        check("hold_regwrite", bus.regwrite, 1'b0);
        check("hold_write_reg", bus.write_reg, 4'd15);
        check("hold_write_data", bus.write_data, 32'hFFFFFFFF);

        // MAC only: two-cycle push-to-write latency, in order
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hCAFEF00D, 1'b0, 1'b1, "mac_only");
        t0 = cyc;
        expect_wr(4'd5, 32'hCAFEF00D, t0 + 2);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h00000001, 1'b0, 1'b1, "mac_only");
        expect_wr(4'd6, 32'h00000001, t0 + 3);
        idle(1'b1, "mac_only_idle");
        idle(1'b1, "mac_only_idle");

        // FIFO fill under ALU traffic, starvation bound, starve counter restart
        step(1'b1, 4'd1,  32'h00000101, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b1, 1'b1, "starve");
        t0 = cyc;
        expect_wr(4'd7, 32'hA5A5A5A5, t0 + 6);
        expect_wr(4'd6, 32'h00000066, t0 + 11);
        expect_wr(4'd8, 32'h00000088, t0 + 13);
        step(1'b1, 4'd2,  32'h00000202, 1'b1, 4'd6, 32'h00000066, 1'b1, 1'b1, "starve");
        step(1'b1, 4'd9,  32'h00000909, 1'b1, 4'd8, 32'h00000088, 1'b1, 1'b0, "full");
        step(1'b1, 4'd10, 32'h00000A0A, 1'b1, 4'd8, 32'h00000088, 1'b1, 1'b0, "full");
        step(1'b1, 4'd11, 32'h00000B0B, 1'b1, 4'd8, 32'h00000088, 1'b1, 1'b0, "full");
        step(1'b1, 4'd12, 32'h00000C0C, 1'b1, 4'd8, 32'h00000088, 1'b0, 1'b0, "forced");
        step(1'b1, 4'd12, 32'h00000C0C, 1'b1, 4'd8, 32'h00000088, 1'b1, 1'b1, "after_force");
        step(1'b1, 4'd13, 32'h00000D0D, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, "starve2");
        step(1'b1, 4'd14, 32'h00000E0E, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, "starve2");
        step(1'b1, 4'd0,  32'h00000F0F, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, "starve2");
        step(1'b1, 4'd15, 32'h0000F00F, 1'b0, 4'd0, 32'd0,        1'b0, 1'b0, "forced2");
        step(1'b1, 4'd15, 32'h0000F00F, 1'b0, 4'd0, 32'd0,        1'b1, 1'b1, "after_force2");
        idle(1'b1, "starve_drain");
        idle(1'b1, "starve_drain");
        idle(1'b1, "starve_drain");

        // Scoreboard: pending MAC to R4 blocks readers, reissue and ALU writes to R4
        nxt_issue     = 1'b1;
        nxt_issue_reg = 4'd4;
        nxt_rd1       = 4'd4;
`ifdef SCOREBOARD_EN
        idle(1'b1, "sb_issue");
        t0 = cyc;
        check("sb_issue_ready_free", bus.mac_issue_ready, 1'b1);
        check("sb_hazard_before", bus.hazard, 1'b0);
        nxt_issue = 1'b0;
        step(1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, "sb_waw");
        check("sb_hazard_set", bus.hazard, 1'b1);
        check("sb_issue_ready_busy", bus.mac_issue_ready, 1'b0);
        step(1'b1, 4'd4, 32'h44444444, 1'b1, 4'd4, 32'h4AC04AC0, 1'b0, 1'b1, "sb_push");
        expect_wr(4'd4, 32'h4AC04AC0, t0 + 4);
        step(1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, "sb_grant");
        check("sb_hazard_at_grant", bus.hazard, 1'b1);
        step(1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, "sb_release");
        check("sb_hazard_clear", bus.hazard, 1'b0);
        check("sb_issue_ready_again", bus.mac_issue_ready, 1'b1);
`else
        step(1'b1, 4'd4, 32'h44444444, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, "nosb_alu");
        check("nosb_hazard", bus.hazard, 1'b0);
        check("nosb_issue_ready", bus.mac_issue_ready, 1'b1);
        nxt_issue = 1'b0;
        idle(1'b1, "nosb_after");
        check("nosb_hazard_after", bus.hazard, 1'b0);
        check("nosb_issue_ready_after", bus.mac_issue_ready, 1'b1);
`endif
        nxt_rd1 = 4'd0;
        idle(1'b1, "sb_drain");
        idle(1'b1, "sb_drain");

        // Reset mid-operation with two entries queued: nothing stale may emerge
        step(1'b1, 4'd1, 32'h00000011, 1'b1, 4'd2, 32'h00000022, 1'b1, 1'b1, "rst_fill");
        step(1'b1, 4'd3, 32'h00000033, 1'b1, 4'd4, 32'h00000044, 1'b1, 1'b1, "rst_fill");
        nxt_reset = 1'b1;
        idle(1'b0, "rst_pulse");
        nxt_reset = 1'b0;
        idle(1'b1, "rst_after");
        check("rst_regwrite", bus.regwrite, 1'b0);
        check("rst_write_reg", bus.write_reg, 4'd0);
        check("rst_write_data", bus.write_data, 32'd0);
        repeat (5) idle(1'b1, "rst_quiet");

        check("pending_writes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
